// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, line/frame strobes, de and syncs.
// Optional colour-bar test pattern outputs when VT_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       newline,
  output logic       newframe,
  output logic       de,
  output logic       hsync,
`ifdef VT_PATTERN_EN
  output logic       pat_R,
  output logic       pat_G,
  output logic       pat_B,
`endif
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        ACT    = (SYNC_POL != 0);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_w;
  logic [10:0] v_w;
  logic        de_nxt;
  logic        hs_nxt;
  logic        vs_nxt;

  // Outputs are computed from the next counter value so they line up with x/y.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
    h_w    = {1'b0, h_nxt};
    v_w    = {1'b0, v_nxt};
    de_nxt = (h_w < HA) && (v_w < VA);
    hs_nxt = (h_w >= HS_BEG && h_w < HS_END) ? ACT : ~ACT;
    vs_nxt = (v_w >= VS_BEG && v_w < VS_END) ? ACT : ~ACT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt    <= H_LAST;
      v_cnt    <= V_LAST;
      x        <= '0;
      y        <= '0;
      newline  <= 1'b0;
      newframe <= 1'b0;
      de       <= 1'b0;
      hsync    <= ~ACT;
      vsync    <= ~ACT;
    end else begin
      newline  <= 1'b0;
      newframe <= 1'b0;
      if (pix_en) begin
        h_cnt    <= h_nxt;
        v_cnt    <= v_nxt;
        x        <= h_nxt;
        y        <= v_nxt;
        newline  <= h_wrap;
        newframe <= h_wrap && v_wrap;
        de       <= de_nxt;
        hsync    <= hs_nxt;
        vsync    <= vs_nxt;
      end
    end
  end

`ifdef VT_PATTERN_EN
  logic [12:0] bar_prod;
  logic [2:0]  bar;
  logic [2:0]  rgb_nxt;

  always_comb begin
    bar_prod = {h_nxt, 3'b000};
    bar      = 3'(bar_prod / 13'(H_ACTIVE));
    rgb_nxt  = de_nxt ? (3'b111 - bar) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_R <= 1'b0;
      pat_G <= 1'b0;
      pat_B <= 1'b0;
    end else if (pix_en) begin
      {pat_R, pat_G, pat_B} <= rgb_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default-timing DUT via a vector table, small-timing DUT
// for whole-frame behaviour, plus reset and pattern sequences.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;

  logic [9:0] x, y;
  logic       newline, newframe, de, hsync, vsync;
  logic [9:0] sx, sy;
  logic       snl, snf, sde, shs, svs;
`ifdef VT_PATTERN_EN
  logic       pat_r, pat_g, pat_b;
  logic       spr, spg, spb;
`endif

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .x(x), .y(y), .newline(newline), .newframe(newframe),
    .de(de), .hsync(hsync),
`ifdef VT_PATTERN_EN
    .pat_R(pat_r), .pat_G(pat_g), .pat_B(pat_b),
`endif
    .vsync(vsync)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .x(sx), .y(sy), .newline(snl), .newframe(snf),
    .de(sde), .hsync(shs),
`ifdef VT_PATTERN_EN
    .pat_R(spr), .pat_G(spg), .pat_B(spb),
`endif
    .vsync(svs)
  );

  typedef struct {
    logic       pe;
    int         n;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       nl, nf, de, hs, vs;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [24:0] pk(input logic [9:0] a, input logic [9:0] b,
                                     input logic l, input logic f,
                                     input logic d, input logic h,
                                     input logic v);
    return {a, b, l, f, d, h, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv(input logic pe, input int n);
    for (int k = 0; k < n; k++) begin
      pix_en = pe;
      @(posedge clk);
      #1;
    end
  endtask

  logic [24:0] dflt_rst;
  logic [24:0] small_rst;
  int hx, vy, nl_cnt, nf_cnt, nf_at, vs_cnt;
  logic [24:0] sexp;

  initial begin
    dflt_rst  = pk(10'd0, 10'd0, 0, 0, 0, 1, 1);
    small_rst = pk(10'd0, 10'd0, 0, 0, 0, 0, 0);

    //          pe  n    x    y   nl nf de hs vs
    tbl[0]  = '{0, 1,   0,   0, 0, 0, 0, 1, 1};
    tbl[1]  = '{1, 1,   0,   0, 1, 1, 1, 1, 1};
    tbl[2]  = '{1, 1,   1,   0, 0, 0, 1, 1, 1};
    tbl[3]  = '{0, 3,   1,   0, 0, 0, 1, 1, 1};
    tbl[4]  = '{1, 638, 639, 0, 0, 0, 1, 1, 1};
    tbl[5]  = '{1, 1,   640, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 15,  655, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{1, 1,   656, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 95,  751, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{1, 1,   752, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{1, 47,  799, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 1,   0,   1, 1, 0, 1, 1, 1};
    tbl[12] = '{1, 799, 799, 1, 0, 0, 0, 1, 1};
    tbl[13] = '{0, 1,   799, 1, 0, 0, 0, 1, 1};
    tbl[14] = '{0, 1,   799, 1, 0, 0, 0, 1, 1};
    tbl[15] = '{1, 1,   0,   2, 1, 0, 1, 1, 1};
    tbl[16] = '{0, 1,   0,   2, 0, 0, 1, 1, 1};
    tbl[17] = '{1, 1,   1,   2, 0, 0, 1, 1, 1};
    tbl[18] = '{1, 299, 300, 2, 0, 0, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dflt", 32'(pk(x, y, newline, newframe, de, hsync, vsync)),
        32'(dflt_rst));
    chk("reset_small", 32'(pk(sx, sy, snl, snf, sde, shs, svs)),
        32'(small_rst));
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      adv(tbl[i].pe, tbl[i].n);
      chk($sformatf("row%0d", i),
          32'(pk(x, y, newline, newframe, de, hsync, vsync)),
          32'(pk(tbl[i].ex, tbl[i].ey, tbl[i].nl, tbl[i].nf,
                 tbl[i].de, tbl[i].hs, tbl[i].vs)));
    end

    // asynchronous reset in the middle of a line
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dflt", 32'(pk(x, y, newline, newframe, de, hsync, vsync)),
        32'(dflt_rst));
    chk("async_rst_small", 32'(pk(sx, sy, snl, snf, sde, shs, svs)),
        32'(small_rst));
    adv(1, 2);
    chk("rst_hold", 32'(pk(x, y, newline, newframe, de, hsync, vsync)),
        32'(dflt_rst));
    #3 rst = 1'b1;
    adv(1, 1);
    chk("restart_dflt", 32'(pk(x, y, newline, newframe, de, hsync, vsync)),
        32'(pk(10'd0, 10'd0, 1, 1, 1, 1, 1)));
    chk("restart_small", 32'(pk(sx, sy, snl, snf, sde, shs, svs)),
        32'(pk(10'd0, 10'd0, 1, 1, 1, 0, 0)));

    // whole frame on the small-timing instance: 32 x 15, active-high syncs
    hx = 0; vy = 0; nl_cnt = 0; nf_cnt = 0; nf_at = -1; vs_cnt = 0;
    for (int c = 1; c <= 480; c++) begin
      hx = hx + 1;
      if (hx == 32) begin
        hx = 0;
        vy = (vy == 14) ? 0 : vy + 1;
      end
      adv(1, 1);
      sexp = pk(10'(hx), 10'(vy), hx == 0, hx == 0 && vy == 0,
                hx < 16 && vy < 8, hx >= 20 && hx < 26,
                vy >= 10 && vy < 12);
      chk($sformatf("frame_c%0d", c),
          32'(pk(sx, sy, snl, snf, sde, shs, svs)), 32'(sexp));
      if (snl) nl_cnt++;
      if (snf) begin
        nf_cnt++;
        nf_at = c;
      end
      if (svs) vs_cnt++;
    end
    chk("newline_count", 32'(nl_cnt), 32'd15);
    chk("newframe_count", 32'(nf_cnt), 32'd1);
    chk("newframe_period", 32'(nf_at), 32'd480);
    chk("vsync_cycles", 32'(vs_cnt), 32'd64);

`ifdef VT_PATTERN_EN
    #2 rst = 1'b0;
    #1;
    chk("pat_reset", 32'({pat_r, pat_g, pat_b}), 32'd0);
    #3 rst = 1'b1;
    adv(1, 1);
    chk("pat_x0", 32'({pat_r, pat_g, pat_b}), 32'b111);
    adv(1, 79);
    chk("pat_x79", 32'({pat_r, pat_g, pat_b}), 32'b111);
    adv(1, 1);
    chk("pat_x80", 32'({pat_r, pat_g, pat_b}), 32'b110);
    adv(1, 479);
    chk("pat_x559", 32'({pat_r, pat_g, pat_b}), 32'b001);
    adv(1, 1);
    chk("pat_x560", 32'({pat_r, pat_g, pat_b}), 32'b000);
    adv(1, 140);
    chk("pat_x700", 32'({pat_r, pat_g, pat_b}), 32'b000);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source that drives the text/menu overlay renderer.
- Produces the pixel/line coordinates (x, y), one-clock newline/newframe strobes, data-enable, and hsync/vsync for the display.
- Sits between the pixel-clock domain and all overlay/renderer blocks; every consumer of x/y/newline/newframe is fed from this block.
- Single clock; pixels advance on a clock-enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- pix_en  input  1  pixel advance enable; one pixel per clk with pix_en=1
- x  output  10  horizontal counter (0..H_TOTAL-1, 0..H_ACTIVE-1 visible)
- y  output  10  vertical counter (0..V_TOTAL-1, 0..V_ACTIVE-1 visible)
- newline  output  1  one-clk pulse when x wraps to 0
- newframe  output  1  one-clk pulse when x and y both wrap to 0
- de  output  1  1 while x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default). Both must be ≤1024; elaboration error otherwise.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- Reset (rst=0, async):
  - internal h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - Outputs: x=0, y=0, newline=0, newframe=0, de=0, hsync=vsync=!SYNC_POL.
- All outputs are registered and mutually aligned. Output values reflect the counter value computed on the same clk edge (0-cycle skew between x/y/de/syncs).
- On clk with pix_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, v_cnt increments, wrapping at V_TOTAL-1 to 0.
- First pix_en after reset therefore yields x=0, y=0, newline=1, newframe=1, de=1.
- newline=1 for exactly one clk, on the edge where h_cnt becomes 0. It is cleared on the next clk even if pix_en stays 1 or goes 0.
- newframe: same rule, only when h_cnt and v_cnt both become 0. newline is also 1 in that cycle.
- hsync active while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 default).
- vsync active while V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 default). It changes only with the line wrap (x=0).
- pix_en=0: every output except newline/newframe holds its value; newline/newframe go to 0.
- Reset asserted mid-line/mid-frame: immediate return to reset values. The restart is identical to power-up.
- No combinational path from pix_en to any output.

Optional Feature:
- Macro VT_PATTERN_EN.
- When defined: adds outputs pat_R, pat_G, pat_B (1 bit each, registered, aligned with x/y).
  - 8 vertical colour bars, each H_ACTIVE/8 wide. Bar index = x*8/H_ACTIVE.
  - {pat_R,pat_G,pat_B} = 3'b111 - bar index (white first, black last).
  - All zero when de=0 and on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, pix_en=1 continuously -> first edge gives x=0, y=0, newline=1, newframe=1, de=1; next edge gives x=1, newline=0, newframe=0.
- Run one line -> x reaches 799 then 0 with newline=1, y=1; de falls at x=640; hsync low for x=656..751 (96 clk), high otherwise.
- Run a full frame -> newline pulses 525 times, newframe exactly once, 420000 clks between newframes; vsync low for y=490..491 only, changing at x=0.
- pix_en toggled 1-0-0-1 around x=799 -> x holds at 799 for two clks; newline=1 only on the single clk where x becomes 0; y increments once.
- rst pulsed low at x=300, y=200 -> outputs go to reset values asynchronously; after release, the first pix_en gives x=0, y=0, newframe=1.
- VT_PATTERN_EN defined, y=10 -> x=0 gives RGB=111, x=80 gives 110, x=560 gives 000, x=700 (blank) gives 000; undefined build compiles without pat_* ports.
